// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write driver.
package lcd_pkg;

  localparam int unsigned CNT_W    = 20;

  localparam int unsigned BIT_ON   = 31;
  localparam int unsigned BIT_REQ  = 10;
  localparam int unsigned BIT_RS   = 9;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef enum logic [2:0] {
    ST_POR,
    ST_IDLE,
    ST_SETUP,
    ST_ENH,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  // Clear and home are the only instructions needing the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_if.sv
// LSU register word in, panel pins and status out.
interface lcd_if;
  import lcd_pkg::*;

  logic [31:0] lcd_word_i;
  logic        lcd_on_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic [7:0]  lcd_data_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  modport master (
    output lcd_word_i,
    input  lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o,
    input  busy_o, done_o, overrun_o
  );

  modport slave (
    input  lcd_word_i,
    output lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o,
    output busy_o, done_o, overrun_o
  );
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter that parks at zero; zero_o marks the last cycle of a phase.
module lcd_timer
  import lcd_pkg::*;
(
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_driver.sv
// Write-only LCD sequencer: power-on wait, then setup / EN pulse / hold / execute
// per transfer, fed from a one-entry request buffer.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int unsigned POR_CYC   = 750000,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned SLOW_CYC  = 82000
) (
  input  logic clk_i,
  input  logic rst_i,
  lcd_if.slave bus
);

  localparam logic [CNT_W-1:0] POR_LD   = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] SLOW_LD  = CNT_W'(SLOW_CYC - 1);

  lcd_state_e       state_q, state_d;
  logic             req_q, req_det, take;
  logic             pend_full_q, pend_rs_q;
  logic [7:0]       pend_data_q;
  logic             rs_q, on_q, ovr_q;
  logic [7:0]       data_q;
  logic             fsm_load, tmr_load, tmr_zero;
  logic [CNT_W-1:0] fsm_val, tmr_val;
  logic             word_unused;

  assign word_unused = ^{bus.lcd_word_i[30:11], bus.lcd_word_i[8]};

  assign req_det = bus.lcd_word_i[BIT_REQ] & ~req_q;
  assign take    = (state_q == ST_IDLE) && pend_full_q;

  // A request arriving in the cycle the entry is taken refills the buffer cleanly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q       <= 1'b0;
      on_q        <= 1'b0;
      ovr_q       <= 1'b0;
      pend_full_q <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= '0;
    end else begin
      req_q <= bus.lcd_word_i[BIT_REQ];
      on_q  <= bus.lcd_word_i[BIT_ON];
      if (req_det && pend_full_q && !take) begin
        ovr_q <= 1'b1;
      end else if (req_det) begin
        pend_full_q <= 1'b1;
        pend_rs_q   <= bus.lcd_word_i[BIT_RS];
        pend_data_q <= bus.lcd_word_i[DATA_MSB:DATA_LSB];
      end else if (take) begin
        pend_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_POR;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        rs_q   <= pend_rs_q;
        data_q <= pend_data_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    fsm_load = 1'b0;
    fsm_val  = '0;
    case (state_q)
      ST_POR:   if (tmr_zero) state_d = ST_IDLE;
      ST_IDLE:  if (pend_full_q) begin
                  state_d  = ST_SETUP;
                  fsm_load = 1'b1;
                  fsm_val  = SETUP_LD;
                end
      ST_SETUP: if (tmr_zero) begin
                  state_d  = ST_ENH;
                  fsm_load = 1'b1;
                  fsm_val  = EN_LD;
                end
      ST_ENH:   if (tmr_zero) begin
                  state_d  = ST_HOLD;
                  fsm_load = 1'b1;
                  fsm_val  = HOLD_LD;
                end
      ST_HOLD:  if (tmr_zero) begin
                  state_d  = ST_EXEC;
                  fsm_load = 1'b1;
                  fsm_val  = is_slow_cmd(rs_q, data_q) ? SLOW_LD : EXEC_LD;
                end
      ST_EXEC:  if (tmr_zero) state_d = ST_IDLE;
      default:  state_d = ST_POR;
    endcase
  end

  // Reset reuses the load path so the POR wait restarts from a full count.
  assign tmr_load = rst_i | fsm_load;
  assign tmr_val  = rst_i ? POR_LD : fsm_val;

  lcd_timer u_timer (
    .clk_i   (clk_i),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .zero_o  (tmr_zero)
  );

  assign bus.lcd_on_o   = on_q;
  assign bus.lcd_rs_o   = rs_q;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_en_o   = (state_q == ST_ENH);
  assign bus.lcd_data_o = data_q;
  assign bus.busy_o     = (state_q != ST_IDLE) || pend_full_q;
  assign bus.done_o     = (state_q == ST_EXEC) && tmr_zero;
  assign bus.overrun_o  = ovr_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver with a cycle-window reference model.
module tb_lcd_driver;

  localparam int P_POR = 10, P_SETUP = 2, P_EN = 3, P_HOLD = 2, P_EXEC = 5, P_SLOW = 20;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic rst_at_edge = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  lcd_if bus ();

  lcd_driver #(
    .POR_CYC   (P_POR),
    .SETUP_CYC (P_SETUP),
    .EN_CYC    (P_EN),
    .HOLD_CYC  (P_HOLD),
    .EXEC_CYC  (P_EXEC),
    .SLOW_CYC  (P_SLOW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_at_edge <= rst_i;

  // Model: pending entry plus the cycle window of the transfer in flight.
  bit         started = 0;
  int         cyc = 0;
  bit         m_pend = 0, m_prs = 0, m_rs = 0, m_ovr = 0, m_on = 0, m_prev_req = 0, x_on = 0;
  logic [7:0] m_pdata = '0, m_data = '0;
  int         x_start = 0, x_dur = 0;
  bit         en_prev = 0;
  int         en_first = -1, en_last = -1, en_total = 0, done_cyc = -1, done_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, need 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    bit in_por, active, launch, det, slow, e_en, e_done, e_busy;
    int ph;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        started = 1; cyc = 0; m_pend = 0; x_on = 0; m_rs = 0; m_data = '0;
        m_ovr = 0; m_on = 0; m_prev_req = 0;
      end
      if (started) begin
        in_por = cyc < P_POR;
        active = x_on && cyc >= x_start && cyc < x_start + x_dur;
        ph     = cyc - x_start;
        e_en   = active && ph >= P_SETUP && ph < P_SETUP + P_EN;
        e_done = active && ph == x_dur - 1;
        e_busy = in_por || active || m_pend;
        check("lcd_en_o",   32'(bus.lcd_en_o),   32'(e_en));
        check("done_o",     32'(bus.done_o),     32'(e_done));
        check("busy_o",     32'(bus.busy_o),     32'(e_busy));
        check("lcd_rs_o",   32'(bus.lcd_rs_o),   32'(m_rs));
        check("lcd_data_o", 32'(bus.lcd_data_o), 32'(m_data));
        check("lcd_on_o",   32'(bus.lcd_on_o),   32'(m_on));
        check("overrun_o",  32'(bus.overrun_o),  32'(m_ovr));
        check("lcd_rw_o",   32'(bus.lcd_rw_o),   32'd0);
        if (bus.lcd_en_o && !en_prev) en_first = cyc;
        if (bus.lcd_en_o) begin en_last = cyc; en_total++; end
        en_prev = bus.lcd_en_o;
        if (bus.done_o) begin done_cyc = cyc; done_total++; end
        if (!rst_i) begin
          launch = !in_por && !active && m_pend;
          if (launch) begin
            m_rs = m_prs; m_data = m_pdata; m_pend = 0; x_on = 1; x_start = cyc + 1;
            slow  = !m_prs && (m_pdata == 8'h01 || m_pdata == 8'h02);
            x_dur = P_SETUP + P_EN + P_HOLD + (slow ? P_SLOW : P_EXEC);
          end
          det = bus.lcd_word_i[10] && !m_prev_req;
          if (det) begin
            if (m_pend) m_ovr = 1;
            else begin m_pend = 1; m_prs = bus.lcd_word_i[9]; m_pdata = bus.lcd_word_i[7:0]; end
          end
          m_prev_req = bus.lcd_word_i[10];
          m_on       = bus.lcd_word_i[31];
          cyc++;
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    bus.lcd_word_i[10]  = 1'b1;
    bus.lcd_word_i[9]   = rs;
    bus.lcd_word_i[7:0] = d;
    step(1);
    bus.lcd_word_i[10]  = 1'b0;
    step(1);
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.busy_o === 1'b0) begin seen = 1; break; end
    end
    check("idle_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin seen = 1; break; end
    end
    check("done_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic stimulus();
    logic [8:0] cmd_tab [4] = '{9'h001, 9'h002, 9'h038, 9'h101};
    int         gap_tab [4] = '{22, 22, 7, 7};
    int d0, e0;

    bus.lcd_word_i = '0;
    step(4);
    rst_i = 1'b0;
    check("rst_busy", 32'(bus.busy_o), 32'd1);

    // Request at cycle 3 of the POR wait.
    step(3);
    send(1'b1, 8'h41);
    wait_idle();
    check("s1_en_first", 32'(en_first), 32'd13);
    check("s1_en_width", 32'(en_total), 32'd3);
    check("s1_done_cyc", 32'(done_cyc), 32'd22);
    check("s1_done_cnt", 32'(done_total), 32'd1);
    check("s1_data",     32'(bus.lcd_data_o), 32'h41);
    check("s1_rs",       32'(bus.lcd_rs_o), 32'd1);

    // Execution wait per instruction: clear/home long, others short.
    for (int i = 0; i < 4; i++) begin
      d0 = done_total;
      send(cmd_tab[i][8], cmd_tab[i][7:0]);
      wait_idle();
      check("exec_len", 32'(done_cyc - en_last), 32'(gap_tab[i]));
      check("exec_done_cnt", 32'(done_total - d0), 32'd1);
    end

    // New request in the very cycle the buffered entry is taken.
    d0 = done_total;
    send(1'b0, 8'h01);
    step(12);
    send(1'b1, 8'h41);
    wait_done();
    bus.lcd_word_i[10] = 1'b1; bus.lcd_word_i[9] = 1'b1; bus.lcd_word_i[7:0] = 8'h42;
    step(1);
    bus.lcd_word_i[10] = 1'b0;
    wait_idle();
    check("refill_ovr",  32'(bus.overrun_o), 32'd0);
    check("refill_data", 32'(bus.lcd_data_o), 32'h42);
    check("refill_cnt",  32'(done_total - d0), 32'd3);

    // Two requests during EXEC: second is dropped.
    d0 = done_total;
    send(1'b0, 8'h01);
    step(8);
    send(1'b1, 8'h41);
    send(1'b1, 8'h42);
    check("ovr_set", 32'(bus.overrun_o), 32'd1);
    wait_idle();
    check("ovr_data", 32'(bus.lcd_data_o), 32'h41);
    check("ovr_cnt",  32'(done_total - d0), 32'd2);

    // Level-held REQ gives exactly one transfer.
    d0 = done_total; e0 = en_total;
    bus.lcd_word_i[10] = 1'b1; bus.lcd_word_i[9] = 1'b1; bus.lcd_word_i[7:0] = 8'h55;
    step(50);
    bus.lcd_word_i[10] = 1'b0;
    wait_idle();
    check("hold_cnt",    32'(done_total - d0), 32'd1);
    check("hold_en",     32'(en_total - e0), 32'd3);
    check("ovr_sticky",  32'(bus.overrun_o), 32'd1);

    // Reset during the EN pulse with an entry pending.
    send(1'b1, 8'h33);
    send(1'b1, 8'h34);
    check("pre_rst_en", 32'(bus.lcd_en_o), 32'd1);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    check("rst_en",  32'(bus.lcd_en_o), 32'd0);
    check("rst_ovr", 32'(bus.overrun_o), 32'd0);
    d0 = done_total;
    step(30);
    check("rst_no_done", 32'(done_total - d0), 32'd0);
    check("rst_idle",    32'(bus.busy_o), 32'd0);
    send(1'b1, 8'h35);
    wait_idle();
    check("rst_new_cnt",  32'(done_total - d0), 32'd1);
    check("rst_new_data", 32'(bus.lcd_data_o), 32'h35);

    // ON bit alone: one-cycle latency, FSM untouched.
    e0 = en_total;
    bus.lcd_word_i[31] = 1'b1;
    check("on_before", 32'(bus.lcd_on_o), 32'd0);
    step(1);
    check("on_after", 32'(bus.lcd_on_o), 32'd1);
    step(3);
    check("on_busy", 32'(bus.busy_o), 32'd0);
    check("on_en",   32'(en_total - e0), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
